// File: rtl/sfifo_pkg.sv
// Shared types and defaults for the sfifo write-port arbiter slice.
package sfifo_pkg;

  // Arbiter FSM: waiting for a requester, or a requester owns the port.
  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

  localparam int unsigned SFIFO_W_DEFAULT = 8;

endpackage

// File: rtl/sfifo_wr_arb_if.sv
// Producer-side handshake plus sfifo write-port signals of the arbiter.
interface sfifo_wr_arb_if #(
  parameter int unsigned W = sfifo_pkg::SFIFO_W_DEFAULT,
  parameter int unsigned N = 4
);
  localparam int unsigned IdxW = $clog2(N);

  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [W-1:0]    fifo_wr_data;
  logic [IdxW-1:0] grant_id;
  logic            busy;

  // Producers and the sfifo side.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_wr_data, grant_id, busy
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_wr_data, grant_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Scan last_i+1 .. last_i+N (mod N); the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(last_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sfifo.sv
// Small synchronous FIFO with show-ahead read data; full/empty come straight from registers.
module sfifo
  import sfifo_pkg::*;
#(
  parameter int unsigned W     = SFIFO_W_DEFAULT,
  parameter int unsigned Depth = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(Depth);

  logic [W-1:0]  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  // Flags and guarded push/pop.
  always_comb begin
    full    = (cnt_q == (AW + 1)'(Depth));
    empty   = (cnt_q == '0);
    do_wr   = wr & ~full;
    do_rd   = rd & ~empty;
    rd_data = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy next state; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
  end

  // Control state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// Round-robin arbiter sharing one sfifo write port among N valid/ready producers,
// with each grant limited to MAX_BURST beats and one idle cycle per grant release.
module sfifo_wr_arb
  import sfifo_pkg::*;
#(
  parameter int unsigned W         = SFIFO_W_DEFAULT,
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  sfifo_wr_arb_if.slave bus
);
  localparam int unsigned   IdxW   = $clog2(N);
  localparam int unsigned   BcW    = $clog2(MAX_BURST + 1);
  localparam logic [BcW-1:0] BcLast = BcW'(MAX_BURST - 1);

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_owner_q, last_owner_d;
  logic [BcW-1:0]  beat_cnt_q, beat_cnt_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            own;
  logic            owner_valid;
  logic            xfer;

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_owner_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Handshake decode; reset masks everything so an in-flight beat is never written.
  always_comb begin
    own         = (state_q == ARB_OWN);
    owner_valid = bus.req_valid[owner_q];
    xfer        = own & owner_valid & ~bus.fifo_full & ~rst;

    bus.req_ready = '0;
    if (xfer) bus.req_ready[owner_q] = 1'b1;
    bus.fifo_wr      = xfer;
    bus.fifo_wr_data = (own && !rst) ? bus.req_data[owner_q*W +: W] : '0;
    bus.grant_id     = rst ? '0 : owner_q;
    bus.busy         = own & ~rst;
  end

  // Next state: grant on any request, release on burst end or dropped valid; full only stalls.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          beat_cnt_d   = '0;
          state_d      = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (!owner_valid) begin
          state_d = ARB_IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BcW'(1);
          if (beat_cnt_q == BcLast) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; last_owner resets to N-1 so requester 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= IdxW'(N - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Scoreboard bench: stimulus queues expected writes/reads, a negedge monitor pops and compares.
module tb_sfifo_wr_arb;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned Depth = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         gap;  // cycles since previous write; 0 = not checked
  } exp_t;

  logic       clk;
  logic       rst;
  logic       fifo_rst;
  logic       force_full;
  logic       rd_en;
  logic       sf_full;
  logic       sf_empty;
  logic       sf_rd;
  logic [7:0] sf_rd_data;

  sfifo_wr_arb_if #(.W(W), .N(N)) arb_if ();

  assign arb_if.fifo_full = sf_full | force_full;
  assign sf_rd = rd_en & ~sf_empty;

  sfifo_wr_arb #(
    .W(W),
    .N(N),
    .MAX_BURST(MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  sfifo #(
    .W(W),
    .Depth(Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (fifo_rst),
    .wr      (arb_if.fifo_wr),
    .wr_data (arb_if.fifo_wr_data),
    .rd      (sf_rd),
    .rd_data (sf_rd_data),
    .full    (sf_full),
    .empty   (sf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  bit         rst_chk = 1'b0;
  bit         stall_chk = 1'b0;
  exp_t       exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  logic [7:0] src_data[N][8];
  int         src_len[N];
  int         src_head[N];
  logic [N-1:0] rdy_s;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: directed window checks, invariants, write and read scoreboards.
  initial begin
    int   cyc;
    int   last_wr_cyc;
    exp_t e;
    logic [7:0] rd_exp;
    cyc = 0;
    last_wr_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_chk) begin
        check("rst_req_ready", 32'(arb_if.req_ready), 0);
        check("rst_fifo_wr", 32'(arb_if.fifo_wr), 0);
        check("rst_busy", 32'(arb_if.busy), 0);
        check("rst_grant_id", 32'(arb_if.grant_id), 0);
        check("rst_wr_data", 32'(arb_if.fifo_wr_data), 0);
      end
      if (stall_chk) begin
        check("stall_req_ready", 32'(arb_if.req_ready), 0);
        check("stall_fifo_wr", 32'(arb_if.fifo_wr), 0);
        check("stall_grant_id", 32'(arb_if.grant_id), 2);
        check("stall_busy", 32'(arb_if.busy), 1);
        check("stall_beat_cnt", 32'(dut.beat_cnt_q), 2);
      end
      check("inv_wr_while_full", 32'(arb_if.fifo_wr & arb_if.fifo_full), 0);
      check("inv_ready_onehot", 32'($countones(arb_if.req_ready) <= 1), 1);
      if (arb_if.fifo_wr) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 32'(arb_if.fifo_wr_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_grant_id", 32'(arb_if.grant_id), 32'(e.id));
          check("wr_data", 32'(arb_if.fifo_wr_data), 32'(e.data));
          if (e.gap != 0) check("wr_gap", 32'(cyc - last_wr_cyc), 32'(e.gap));
        end
        last_wr_cyc = cyc;
      end
      if (sf_rd) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_read", 32'(sf_rd_data), 32'hFFFF_FFFF);
        end else begin
          rd_exp = exp_rd_q.pop_front();
          check("rd_data", 32'(sf_rd_data), 32'(rd_exp));
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (src_head[i] < src_len[i]) begin
        arb_if.req_valid[i] = 1'b1;
        arb_if.req_data[i*W +: W] = src_data[i][src_head[i]];
      end else begin
        arb_if.req_valid[i] = 1'b0;
        arb_if.req_data[i*W +: W] = '0;
      end
    end
  endtask

  // One cycle: sample ready away from the edge, then advance producers after it.
  task automatic tick();
    @(negedge clk);
    rdy_s = arb_if.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (rdy_s[i]) src_head[i]++;
    drive();
  endtask

  task automatic load(int id, int base, int n);
    for (int k = 0; k < n; k++) src_data[id][k] = 8'(base + k);
    src_len[id]  = n;
    src_head[id] = 0;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < int'(N); i++) begin
      src_len[i]  = 0;
      src_head[i] = 0;
    end
  endtask

  task automatic expect_beat(int id, int data, int gap);
    exp_t e;
    e.id   = 2'(id);
    e.data = 8'(data);
    e.gap  = gap;
    exp_wr_q.push_back(e);
    exp_rd_q.push_back(8'(data));
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_wr_q.size() == 0) && (exp_rd_q.size() == 0);
    for (int i = 0; i < int'(N); i++) if (src_head[i] < src_len[i]) d = 1'b0;
    return d;
  endfunction

  task automatic settle(string name);
    int t;
    t = 0;
    while (!all_done() && t < 200) begin
      tick();
      t++;
    end
    check({name, "_complete"}, 32'(all_done()), 1);
    repeat (3) tick();
  endtask

  task automatic wait_head(int id, int n);
    int t;
    t = 0;
    while (src_head[id] < n && t < 50) begin
      tick();
      t++;
    end
    check("wait_head_reached", 32'(src_head[id] >= n), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every requester asserting valid.
    rst        = 1'b1;
    fifo_rst   = 1'b1;
    force_full = 1'b0;
    rd_en      = 1'b1;
    clear_srcs();
    arb_if.req_valid = '1;
    arb_if.req_data  = 32'h3322_1100;
    rst_chk = 1'b1;
    repeat (2) tick();
    rst_chk  = 1'b0;
    rst      = 1'b0;
    fifo_rst = 1'b0;
    drive();

    // Single requester streaming six beats: burst of four, bubble, re-grant for two.
    load(1, 'h10, 6);
    expect_beat(1, 'h10, 0);
    expect_beat(1, 'h11, 1);
    expect_beat(1, 'h12, 1);
    expect_beat(1, 'h13, 1);
    expect_beat(1, 'h14, 2);
    expect_beat(1, 'h15, 1);
    drive();
    settle("burst_split");

    // Rotation from a fresh reset: 0,1,2,3,0 with four beats each.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(0, 'h00, 8);
    load(1, 'h10, 4);
    load(2, 'h20, 4);
    load(3, 'h30, 4);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        expect_beat(g % 4, (g == 4) ? (4 + b) : ((g * 16) + b),
                    (b == 0) ? ((g == 0) ? 0 : 2) : 1);
      end
    end
    drive();
    settle("rotation");

    // Backpressure: full for three cycles after requester 2's second beat.
    load(2, 'hA0, 4);
    expect_beat(2, 'hA0, 0);
    expect_beat(2, 'hA1, 1);
    expect_beat(2, 'hA2, 4);
    expect_beat(2, 'hA3, 1);
    drive();
    wait_head(2, 2);
    force_full = 1'b1;
    stall_chk  = 1'b1;
    repeat (3) tick();
    force_full = 1'b0;
    stall_chk  = 1'b0;
    settle("backpressure");

    // Early release: requester 3 offers a single beat while requester 0 waits.
    load(3, 'hB0, 1);
    load(0, 'hC0, 2);
    expect_beat(3, 'hB0, 0);
    expect_beat(0, 'hC0, 3);
    expect_beat(0, 'hC1, 1);
    drive();
    settle("early_release");

    // Reset during requester 1's third beat; that beat must reappear later.
    load(1, 'hD0, 4);
    load(0, 'hE0, 1);
    expect_beat(1, 'hD0, 0);
    expect_beat(1, 'hD1, 1);
    expect_beat(0, 'hE0, 3);
    expect_beat(1, 'hD2, 3);
    expect_beat(1, 'hD3, 1);
    drive();
    wait_head(1, 2);
    rst     = 1'b1;
    rst_chk = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rst_chk = 1'b0;
    settle("reset_mid_burst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
